// File: rtl/evt_readout_seq.sv
// Event readout sequencer: on trigger, drains one PKT_LEN-word packet from each
// FWFT channel buffer in order 0..N_CH-1 onto a single valid/ready stream.
module evt_readout_seq #(
  parameter int unsigned N_CH    = 16,
  parameter int unsigned PKT_LEN = 516,
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 trig,
  input  logic [N_CH-1:0]      ch_empty,
  input  logic [16*N_CH-1:0]   ch_data,
  output logic [N_CH-1:0]      ch_rd,
  output logic [15:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 busy,
  output logic                 abort,
  output logic [15:0]          evt_cnt,
  output logic [7:0]           lost_cnt,
  output logic [7:0]           abort_cnt,
  output logic                 err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE, S_ABORT} state_t;

  localparam logic [3:0]  LAST_CH   = 4'(N_CH - 1);
  localparam logic [9:0]  LAST_WORD = 10'(PKT_LEN - 1);
  localparam logic [15:0] STALL_MAX = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [3:0]  ch_q;
  logic [9:0]  word_q;
  logic [15:0] stall_q;
  logic        busy_q;
  logic        abort_q;
  logic [15:0] evt_cnt_q;
  logic [7:0]  lost_cnt_q;
  logic [7:0]  abort_cnt_q;
  logic        err_q;

  logic        sel_empty;
  logic [15:0] sel_data;
  logic        accept;

  always_comb begin
    sel_empty = 1'b1;
    sel_data  = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_q == 4'(i)) begin
        sel_empty = ch_empty[i];
        sel_data  = ch_data[16*i +: 16];
      end
    end
  end

  assign out_data  = sel_data;
  assign out_valid = (state_q == S_XFER) && !sel_empty;
  assign accept    = out_valid && out_ready;
  assign out_sof   = out_valid && (ch_q == '0) && (word_q == '0);
  assign out_eof   = out_valid && (ch_q == LAST_CH) && (word_q == LAST_WORD);

  // Pops are gated by reset_n directly so a reset cycle never consumes a word.
  always_comb begin
    ch_rd = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch_rd[i] = reset_n && accept && (ch_q == 4'(i));
    end
  end

  assign busy        = busy_q;
  assign abort       = abort_q;
  assign evt_cnt     = evt_cnt_q;
  assign lost_cnt    = lost_cnt_q;
  assign abort_cnt   = abort_cnt_q;
  assign err_timeout = err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      word_q      <= '0;
      stall_q     <= '0;
      busy_q      <= 1'b0;
      abort_q     <= 1'b0;
      evt_cnt_q   <= '0;
      lost_cnt_q  <= '0;
      abort_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      if (trig && (state_q != S_IDLE) && (lost_cnt_q != '1)) begin
        lost_cnt_q <= lost_cnt_q + 8'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (trig) begin
            state_q <= S_XFER;
            ch_q    <= '0;
            word_q  <= '0;
            stall_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_XFER: begin
          if (accept) begin
            stall_q <= '0;
            if (word_q == LAST_WORD) begin
              word_q <= '0;
              if (ch_q == LAST_CH) begin
                state_q   <= S_DONE;
                evt_cnt_q <= evt_cnt_q + 16'd1;
              end else begin
                ch_q <= ch_q + 4'd1;
              end
            end else begin
              word_q <= word_q + 10'd1;
            end
          end else if (!out_valid) begin
            // Counter/flag updates land on entry so they line up with the abort pulse.
            if (stall_q == STALL_MAX) begin
              state_q <= S_ABORT;
              busy_q  <= 1'b0;
              abort_q <= 1'b1;
              err_q   <= 1'b1;
              if (abort_cnt_q != '1) abort_cnt_q <= abort_cnt_q + 8'd1;
            end else begin
              stall_q <= stall_q + 16'd1;
            end
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_ABORT: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_evt_readout_seq.sv
// Bench for evt_readout_seq: bench-owned FWFT queues, an event-level reference
// model checked every cycle, plus directed literal checks on key scenarios.
module tb_evt_readout_seq;
  localparam int N  = 4;
  localparam int L  = 8;
  localparam int TO = 16;
  localparam int M_IDLE = 0, M_XFER = 1, M_DONE = 2, M_ABORT = 3;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           trig = 1'b0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   ch_empty;
  logic [16*N-1:0] ch_data;
  logic [N-1:0]   ch_rd;
  logic [15:0]    out_data;
  logic           out_valid, out_sof, out_eof, busy, abort, err_timeout;
  logic [15:0]    evt_cnt;
  logic [7:0]     lost_cnt, abort_cnt;

  evt_readout_seq #(.N_CH(N), .PKT_LEN(L), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .trig(trig), .ch_empty(ch_empty),
    .ch_data(ch_data), .ch_rd(ch_rd), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sof(out_sof),
    .out_eof(out_eof), .busy(busy), .abort(abort), .evt_cnt(evt_cnt),
    .lost_cnt(lost_cnt), .abort_cnt(abort_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  logic [15:0] q[N][$];
  logic [N-1:0] avail = '1;
  logic [N-1:0] pend_pop = '0;
  bit refill = 0, toggle_rdy = 0;

  int vectors = 0, miscompares = 0, nfail = 0;

  // Event-level model: position p counts words accepted in the current event.
  int m_mode = M_IDLE, m_p = 0, m_starve = 0, m_lost = 0, m_abc = 0;
  logic [15:0] m_evt = '0;
  bit m_err = 0, m_ok = 0;

  logic [15:0] acc[$];
  int cyc = 0, busy_cyc = 0, last_acc = 0, abort_at = -1, sof_at = -1, eof_at = -1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      if (nfail < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      nfail++;
    end
  endtask

  function automatic void refresh();
    for (int i = 0; i < N; i++) begin
      ch_empty[i] = !(avail[i] && q[i].size() != 0);
      ch_data[16*i +: 16] = (q[i].size() != 0) ? q[i][0] : 16'hBAD0;
    end
  endfunction

  task automatic cycle_check();
    int c;
    bit ev;
    logic [N-1:0] exp_rd;
    cyc++;
    if (m_ok) begin
      ev = 0;
      exp_rd = '0;
      c = m_p / L;
      if (m_mode == M_XFER) begin
        ev = !ch_empty[c];
        if (ev && out_ready && reset_n) exp_rd[c] = 1'b1;
      end
      chk("ch_rd", 32'(ch_rd), 32'(exp_rd));
      if (reset_n) begin
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("out_sof", 32'(out_sof), 32'(ev && m_p == 0));
        chk("out_eof", 32'(out_eof), 32'(ev && m_p == N*L-1));
        if (ev) chk("out_data", 32'(out_data), 32'(q[c][0]));
      end
      chk("busy", 32'(busy), 32'(m_mode == M_XFER || m_mode == M_DONE));
      chk("abort", 32'(abort), 32'(m_mode == M_ABORT));
      chk("evt_cnt", 32'(evt_cnt), 32'(m_evt));
      chk("lost_cnt", 32'(lost_cnt), 32'(m_lost));
      chk("abort_cnt", 32'(abort_cnt), 32'(m_abc));
      chk("err_timeout", 32'(err_timeout), 32'(m_err));
    end
    if (busy) busy_cyc++;
    if (abort && abort_at < 0) abort_at = cyc;
    if (out_valid && out_ready && reset_n) begin
      if (out_sof) sof_at = acc.size();
      if (out_eof) eof_at = acc.size();
      acc.push_back(out_data);
      last_acc = cyc;
    end
    pend_pop = ch_rd;
    // Model step for the edge that follows.
    if (!reset_n) begin
      m_mode = M_IDLE; m_p = 0; m_starve = 0; m_evt = '0;
      m_lost = 0; m_abc = 0; m_err = 0; m_ok = 1;
    end else if (m_ok) begin
      if (trig && m_mode != M_IDLE && m_lost != 255) m_lost++;
      case (m_mode)
        M_IDLE: if (trig) begin m_mode = M_XFER; m_p = 0; m_starve = 0; end
        M_XFER: begin
          if (!ch_empty[m_p / L] && out_ready) begin
            m_p++;
            m_starve = 0;
            if (m_p == N*L) begin m_mode = M_DONE; m_evt = m_evt + 16'd1; end
          end else if (ch_empty[m_p / L]) begin
            m_starve++;
            if (m_starve == TO) begin
              m_mode = M_ABORT; m_err = 1;
              if (m_abc != 255) m_abc++;
            end
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cycle_check();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (pend_pop[i] && q[i].size() != 0) void'(q[i].pop_front());
    if (refill)
      for (int i = 0; i < N; i++)
        if (q[i].size() < 4) repeat (8) q[i].push_back(16'($urandom));
    if (toggle_rdy) out_ready = ~out_ready;
    refresh();
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int n;
    n = 0;
    tick();
    while ((busy || abort) && n < maxc) begin tick(); n++; end
    if (n >= maxc) begin
      vectors++; miscompares++;
      $display("FAIL %s: still busy after %0d cycles, required idle", nm, maxc);
    end
  endtask

  task automatic load(input int short_ch, input int short_n);
    for (int c = 0; c < N; c++)
      for (int w = 0; w < ((c == short_ch) ? short_n : L); w++)
        q[c].push_back(16'(c*256 + w));
    refresh();
  endtask

  task automatic clear_q();
    for (int c = 0; c < N; c++) q[c].delete();
    refresh();
  endtask

  task automatic pulse_trig();
    tick(); trig = 1'b1;
    tick(); trig = 1'b0;
  endtask

  task automatic check_stream(input string nm, input int base);
    int bad;
    bad = 0;
    chk({nm, "_words"}, 32'(acc.size() - base), 32'd32);
    for (int k = 0; k < 32; k++)
      if (base + k >= acc.size() || acc[base + k] !== 16'((k / 8) * 256 + k % 8)) bad++;
    chk({nm, "_order"}, 32'(bad), 32'd0);
    chk({nm, "_sof_at"}, 32'(sof_at), 32'(base));
    chk({nm, "_eof_at"}, 32'(eof_at), 32'(base + 31));
  endtask

  initial begin
    int base, blank_ch, blank_left;
    blank_ch = 0; blank_left = 0;
    refresh();
    repeat (3) tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_evt", 32'(evt_cnt), 32'd0);
    reset_n = 1'b1; out_ready = 1'b1;

    // Full event
    load(-1, 0);
    base = acc.size(); busy_cyc = 0;
    pulse_trig();
    wait_idle(200, "full_event");
    check_stream("full", base);
    chk("full_busy_cycles", 32'(busy_cyc), 32'd33);
    chk("full_evt_cnt", 32'(evt_cnt), 32'd1);

    // Backpressure: ready high in the first XFER cycle, then alternating
    load(-1, 0);
    base = acc.size(); busy_cyc = 0;
    tick(); trig = 1'b1; out_ready = 1'b0; toggle_rdy = 1;
    tick(); trig = 1'b0;
    wait_idle(200, "backpressure");
    toggle_rdy = 0; out_ready = 1'b1;
    check_stream("bp", base);
    chk("bp_busy_cycles", 32'(busy_cyc), 32'd64);
    chk("bp_abort_cnt", 32'(abort_cnt), 32'd0);
    chk("bp_evt_cnt", 32'(evt_cnt), 32'd2);

    // Starvation abort: channel 2 runs dry after 3 words
    load(2, 3);
    abort_at = -1;
    pulse_trig();
    wait_idle(200, "starve_abort");
    // TIMEOUT edges after the accepting edge is TIMEOUT+1 sample cycles later
    chk("abort_latency", 32'(abort_at - last_acc), 32'd17);
    chk("abort_cnt_1", 32'(abort_cnt), 32'd1);
    chk("err_timeout_set", 32'(err_timeout), 32'd1);
    chk("abort_evt_cnt", 32'(evt_cnt), 32'd2);
    clear_q();

    // Lost triggers during one event, then a second event
    load(-1, 0); load(-1, 0);
    tick(); trig = 1'b1;
    for (int j = 1; j <= 10; j++) begin tick(); trig = (j % 2 == 0); end
    tick(); trig = 1'b0;
    wait_idle(200, "lost_evt1");
    pulse_trig();
    wait_idle(200, "lost_evt2");
    chk("lost_cnt_5", 32'(lost_cnt), 32'd5);
    chk("lost_evt_cnt", 32'(evt_cnt), 32'd4);
    clear_q();

    // Reset mid-event at word 10
    load(-1, 0);
    pulse_trig();
    for (int n = 0; n < 50 && !(m_mode == M_XFER && m_p == 10); n++) tick();
    chk("at_word10", 32'(m_p), 32'd10);
    reset_n = 1'b0;
    #2;
    chk("rst_no_pop", 32'(ch_rd), 32'd0);
    tick(); reset_n = 1'b1;
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_evt", 32'(evt_cnt), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    chk("rst_abort_cnt", 32'(abort_cnt), 32'd0);
    clear_q();

    // Randomized traffic with starvation bursts and rare resets
    refill = 1;
    repeat (3000) begin
      tick();
      trig      = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      reset_n   = ($urandom_range(0, 699) != 0);
      if (blank_left > 0) blank_left--;
      else if ($urandom_range(0, 59) == 0) begin
        blank_ch = $urandom_range(0, N-1);
        blank_left = $urandom_range(5, 30);
      end
      avail = '1;
      if (blank_left > 0) avail[blank_ch] = 1'b0;
      refresh();
    end

    // lost_cnt saturation with trig held high
    avail = '1; out_ready = 1'b1; trig = 1'b0; reset_n = 1'b0;
    refresh();
    repeat (2) tick();
    reset_n = 1'b1; trig = 1'b1;
    repeat (400) tick();
    chk("lost_sat", 32'(lost_cnt), 32'd255);
    trig = 1'b0;
    wait_idle(200, "sat_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
